instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Streaming instruction encoder: packs opcode, register fields and an immediate into a 32-bit RV32I word.
//  It is the inverse of the decode-side immediate extraction, so encode-then-decode reproduces the same immediate.
//  Feeds the instruction-memory loader and the self-test program builder; tags every word with a write address.
//  Two-stage valid/ready pipeline, range checking, auto-incrementing address and a saturating error counter.
// PARAMETERS
//  ADDR_W      32       width of o_Addr / i_AddrLoadValue
//  RESET_ADDR  0        address counter value after reset (must be word aligned)
//  ERRCNT_W    8        width of o_ErrCount
// PORTS
//  i_Clk            in   1       clock, rising edge
//  i_Rst_n          in   1       asynchronous, active-low reset
//  i_Flush          in   1       synchronous pipeline flush
//  i_Valid          in   1       request valid
//  o_Ready          out  1       request accepted when i_Valid & o_Ready
//  i_Opcode         in   7       opcode; uses `OP_R_TYPE/`OP_I_TYPE/`OP_I_L_TYPE/`OP_S_TYPE/`OP_B_TYPE/`OP_LUI/`OP_AUIPC/`OP_JAL
//  i_Rd,i_Rs1,i_Rs2 in   5 each  register indices
//  i_Funct3         in   3       funct3
//  i_Funct7         in   7       funct7 (R type only)
//  i_Imm            in   data_t  immediate, decode-side representation (below)
//  i_AddrLoad       in   1       load address counter
//  i_AddrLoadValue  in   ADDR_W  new counter value; bits [1:0] forced to 0
//  o_Valid          out  1       output word valid
//  i_Ready          in   1       downstream ready; transfer when o_Valid & i_Ready
//  o_Instruction    out  data_t  encoded word
//  o_Addr           out  ADDR_W  address tagged to o_Instruction
//  o_Err            out  1       word had a range error or an unsupported opcode
//  o_ErrCount       out  ERRCNT_W  errored words accepted since reset; saturates at all-ones
// BEHAVIOUR
//  Reset: o_Valid=0, o_Instruction=0, o_Addr=0, o_Err=0, o_ErrCount=0, address counter=RESET_ADDR, both stage valids=0.
//  Immediate representation and placement (i = i_Imm):
//   R: {funct7,rs2,rs1,funct3,rd,op}; i_Imm ignored; never a range error.
//   I, I_L: inst[31:20]=i[11:0]; legal range -2048..2047.
//   S: inst[31:25]=i[11:5], inst[11:7]=i[4:0]; range -2048..2047.
//   B: i is the halfword offset: inst[31]=i[11], inst[7]=i[10], inst[30:25]=i[9:4], inst[11:8]=i[3:0]; range -2048..2047.
//   LUI/AUIPC: inst[31:12]=i[19:0]; range -2^19..2^19-1.
//   JAL: i is the halfword offset: inst[31]=i[19], inst[30:21]=i[9:0], inst[20]=i[10], inst[19:12]=i[18:11]; range -2^19..2^19-1.
//   Out of range: field is truncated to its low bits, word is still emitted, and Err=1.
//   Unsupported opcode: opcode, rd, rs1, rs2 and funct3 are placed as in R type, funct7/imm bits are 0, and Err=1.
//  Pipeline: S1 registers the packed word, Err and Addr; S2 is the output register.
//   Advance = !S2Valid | i_Ready. o_Ready = !S1Valid | Advance.
//   o_Ready depends combinationally on i_Ready.
//   Latency: 2 cycles from accept to o_Valid. Throughput: 1 word/cycle.
//   With i_Ready=0, at most 2 words are held. No word is lost or duplicated.
//   Outputs stay stable while o_Valid & !i_Ready.
//  Address: the word accepted in a cycle takes the current counter value, then the counter increments by 4.
//   Wraps modulo 2^ADDR_W.
//   i_AddrLoad alone: counter <= load value.
//   i_AddrLoad with an accept in the same cycle: the accepted word takes the load value; counter <= load value+4.
//  o_ErrCount increments when an Err=1 word enters S1, not when it leaves S2.
//  i_Flush: S1Valid=S2Valid=0 next cycle; any accept in that cycle is discarded (not counted, no address increment).
//   The address counter and o_ErrCount are kept. Flush takes priority over accept and advance.
//  Asynchronous reset mid-stream: all state returns to reset values immediately; held words are dropped.
// TESTING
//  1 addi: op=0010011, rd=1, rs1=0, f3=0, imm=32'hFFFFFFFF -> o_Instruction=32'hFFF00093, o_Err=0, o_Valid 2 cycles after accept, o_Addr=0.
//  2 sw/beq/lui back-to-back, i_Ready=1:
//    sw rs1=2, rs2=5, f3=2, imm=8 -> 32'h00512423 @0
//    beq imm=4 -> 32'h00000463 @4
//    lui rd=1, imm=32'h12345 -> 32'h123450B7 @8
//  3 Range: I type, rd=1, imm=2048 -> 32'h80000093, o_Err=1, o_ErrCount=1; JAL imm=2^19 -> o_Err=1, o_ErrCount=2.
//  4 Backpressure: i_Ready=0 with 3 requests -> o_Ready drops after 2 accepts.
//    Release i_Ready -> words emerge in order with o_Addr 0, 4, 8 and no duplicates.
//  5 Address load: i_AddrLoad=1, value=32'h103 with a same-cycle accept -> that word gets o_Addr=32'h100, the next gets 32'h104.
//  6 Flush and reset: i_Flush with 2 words held -> o_Valid=0 next cycle, counters kept.
//    Deassert i_Rst_n mid-stream -> o_Valid=0 and o_ErrCount=0 immediately, o_Addr=0; the next word gets RESET_ADDR.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode, register fields and immediate into an RV32I word
// through a two-stage valid/ready pipeline, tagging each word with an address.
module instr_encoder #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0,
  parameter int                 ERRCNT_W   = 8
) (
  input  logic                i_Clk,
  input  logic                i_Rst_n,
  input  logic                i_Flush,
  input  logic                i_Valid,
  output logic                o_Ready,
  input  logic [6:0]          i_Opcode,
  input  logic [4:0]          i_Rd,
  input  logic [4:0]          i_Rs1,
  input  logic [4:0]          i_Rs2,
  input  logic [2:0]          i_Funct3,
  input  logic [6:0]          i_Funct7,
  input  logic [31:0]         i_Imm,
  input  logic                i_AddrLoad,
  input  logic [ADDR_W-1:0]   i_AddrLoadValue,
  output logic                o_Valid,
  input  logic                i_Ready,
  output logic [31:0]         o_Instruction,
  output logic [ADDR_W-1:0]   o_Addr,
  output logic                o_Err,
  output logic [ERRCNT_W-1:0] o_ErrCount
);
  localparam logic [6:0] OP_R_TYPE   = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE   = 7'b0010011;
  localparam logic [6:0] OP_I_L_TYPE = 7'b0000011;
  localparam logic [6:0] OP_S_TYPE   = 7'b0100011;
  localparam logic [6:0] OP_B_TYPE   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  logic                s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic [31:0]         s1_word_q, s1_word_d, s2_word_q, s2_word_d;
  logic                s1_err_q, s1_err_d, s2_err_q, s2_err_d;
  logic [ADDR_W-1:0]   s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d, base;
  logic [ERRCNT_W-1:0] ec_q, ec_d;
  logic [31:0]         word;
  logic                bad, fits12, fits20, adv, acc;

  // A value fits in N signed bits when every bit from N-1 upward matches.
  assign fits12 = (&i_Imm[31:11]) | ~(|i_Imm[31:11]);
  assign fits20 = (&i_Imm[31:19]) | ~(|i_Imm[31:19]);

  always_comb begin
    word = {7'b0, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
    bad  = 1'b1;
    case (i_Opcode)
      OP_R_TYPE: begin
        word = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_Opcode};
        bad  = 1'b0;
      end
      OP_I_TYPE, OP_I_L_TYPE: begin
        word = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, i_Opcode};
        bad  = !fits12;
      end
      OP_S_TYPE: begin
        word = {i_Imm[11:5], i_Rs2, i_Rs1, i_Funct3, i_Imm[4:0], i_Opcode};
        bad  = !fits12;
      end
      OP_B_TYPE: begin
        word = {i_Imm[11], i_Imm[9:4], i_Rs2, i_Rs1, i_Funct3, i_Imm[3:0], i_Imm[10], i_Opcode};
        bad  = !fits12;
      end
      OP_LUI, OP_AUIPC: begin
        word = {i_Imm[19:0], i_Rd, i_Opcode};
        bad  = !fits20;
      end
      OP_JAL: begin
        word = {i_Imm[19], i_Imm[9:0], i_Imm[10], i_Imm[18:11], i_Rd, i_Opcode};
        bad  = !fits20;
      end
      default: ;
    endcase
  end

  assign adv     = !s2_valid_q | i_Ready;
  assign o_Ready = !s1_valid_q | adv;
  assign acc     = i_Valid & o_Ready & !i_Flush;
  assign base    = i_AddrLoad ? (i_AddrLoadValue & ~ADDR_W'(3)) : cnt_q;

  always_comb begin
    cnt_d      = acc ? base + ADDR_W'(4) : base;
    ec_d       = (acc & bad & ~(&ec_q)) ? ec_q + ERRCNT_W'(1) : ec_q;
    s1_valid_d = i_Flush ? 1'b0 : (acc | (s1_valid_q & !adv));
    s2_valid_d = i_Flush ? 1'b0 : (adv ? s1_valid_q : s2_valid_q);
    s1_word_d  = acc ? word : s1_word_q;
    s1_err_d   = acc ? bad : s1_err_q;
    s1_addr_d  = acc ? base : s1_addr_q;
    s2_word_d  = adv ? s1_word_q : s2_word_q;
    s2_err_d   = adv ? s1_err_q : s2_err_q;
    s2_addr_d  = adv ? s1_addr_q : s2_addr_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_word_q  <= '0;
      s1_err_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_word_q  <= '0;
      s2_err_q   <= 1'b0;
      s2_addr_q  <= '0;
      cnt_q      <= RESET_ADDR;
      ec_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_word_q  <= s1_word_d;
      s1_err_q   <= s1_err_d;
      s1_addr_q  <= s1_addr_d;
      s2_word_q  <= s2_word_d;
      s2_err_q   <= s2_err_d;
      s2_addr_q  <= s2_addr_d;
      cnt_q      <= cnt_d;
      ec_q       <= ec_d;
    end
  end

  assign o_Valid       = s2_valid_q;
  assign o_Instruction = s2_word_q;
  assign o_Addr        = s2_addr_q;
  assign o_Err         = s2_err_q;
  assign o_ErrCount    = ec_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: vector table plus scoreboard queue checking instr_encoder words,
// addresses, error flags and counters, with hand-written backpressure/flush/reset sequences.
module tb_instr_encoder;
  logic        clk;
  logic        i_Rst_n, i_Flush, i_Valid, o_Ready, i_AddrLoad, o_Valid, i_Ready, o_Err;
  logic [6:0]  i_Opcode, i_Funct7;
  logic [4:0]  i_Rd, i_Rs1, i_Rs2;
  logic [2:0]  i_Funct3;
  logic [31:0] i_Imm, i_AddrLoadValue, o_Instruction, o_Addr;
  logic [7:0]  o_ErrCount;

  instr_encoder dut (
    .i_Clk(clk), .i_Rst_n(i_Rst_n), .i_Flush(i_Flush), .i_Valid(i_Valid), .o_Ready(o_Ready),
    .i_Opcode(i_Opcode), .i_Rd(i_Rd), .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .i_Funct3(i_Funct3),
    .i_Funct7(i_Funct7), .i_Imm(i_Imm), .i_AddrLoad(i_AddrLoad), .i_AddrLoadValue(i_AddrLoadValue),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Instruction(o_Instruction), .o_Addr(o_Addr),
    .o_Err(o_Err), .o_ErrCount(o_ErrCount)
  );

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] ei;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] i;
    logic [31:0] a;
    logic        e;
  } exp_t;

  vec_t        tab [16];
  exp_t        q [$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_addr = 0;
  logic [7:0]  exp_ec = 0;
  logic [31:0] cur_ei;
  logic        cur_ee;
  logic        hold_v = 0;
  logic [63:0] hold_w;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic vld);
    i_Opcode = v.op; i_Rd = v.rd; i_Rs1 = v.rs1; i_Rs2 = v.rs2;
    i_Funct3 = v.f3; i_Funct7 = v.f7; i_Imm = v.imm; i_Valid = vld;
    cur_ei = v.ei; cur_ee = v.ee;
  endtask

  // Sample just after the falling edge, update the model, then wait one cycle.
  task automatic cycle();
    exp_t        e;
    logic [31:0] b;
    #1;
    chk("errcount", {56'd0, o_ErrCount}, {56'd0, exp_ec});
    if (hold_v && o_Valid) chk("held_stable", {o_Instruction, o_Addr}, hold_w);
    hold_v = o_Valid && !i_Ready;
    hold_w = {o_Instruction, o_Addr};
    if (o_Valid && i_Ready) begin
      if (q.size() == 0) chk("spurious_word", {63'd0, o_Valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("instr", {32'd0, o_Instruction}, {32'd0, e.i});
        chk("addr", {32'd0, o_Addr}, {32'd0, e.a});
        chk("err", {63'd0, o_Err}, {63'd0, e.e});
      end
    end
    b = i_AddrLoad ? (i_AddrLoadValue & ~32'd3) : exp_addr;
    if (i_Flush) begin
      q.delete();
      exp_addr = b;
    end else if (i_Valid && o_Ready) begin
      q.push_back('{i: cur_ei, a: b, e: cur_ee});
      exp_addr = b + 32'd4;
      if (cur_ee && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
    end else exp_addr = b;
    @(negedge clk);
  endtask

  task automatic drain();
    i_Valid = 1'b0; i_Ready = 1'b1; i_AddrLoad = 1'b0;
    for (int k = 0; k < 20 && (q.size() != 0 || o_Valid); k++) cycle();
    chk("drain_done", {32'd0, q.size()}, 64'd0);
  endtask

  initial begin
    tab[0]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    tab[1]  = '{7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd8,        32'h00512423, 1'b0};
    tab[2]  = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4,        32'h00000463, 1'b0};
    tab[3]  = '{7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345,    32'h123450B7, 1'b0};
    tab[4]  = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF,    32'h402081B3, 1'b0};
    tab[5]  = '{7'b0000011, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFFC12283, 1'b0};
    tab[6]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h80000093, 1'b1};
    tab[7]  = '{7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h80000,    32'h8000006F, 1'b1};
    tab[8]  = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFFFF0EF, 1'b0};
    tab[9]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000093, 1'b0};
    tab[10] = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF, 32'h7FF00093, 1'b1};
    tab[11] = '{7'b0010111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFFF,    32'h7FFFF117, 1'b0};
    tab[12] = '{7'b0110111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h80000,    32'h80000037, 1'b1};
    tab[13] = '{7'b1110011, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F, 32'd5,       32'h003110F3, 1'b1};
    tab[14] = '{7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFE000FE3, 1'b0};
    tab[15] = '{7'b0100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF7FF, 32'h7E000FA3, 1'b1};

    i_Rst_n = 1'b0; i_Flush = 1'b0; i_Ready = 1'b1; i_AddrLoad = 1'b0; i_AddrLoadValue = 0;
    drive(tab[0], 1'b0);
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_valid", {63'd0, o_Valid}, 64'd0);
    chk("rst_instr", {32'd0, o_Instruction}, 64'd0);
    chk("rst_addr", {32'd0, o_Addr}, 64'd0);
    chk("rst_err", {63'd0, o_Err}, 64'd0);
    chk("rst_errcount", {56'd0, o_ErrCount}, 64'd0);
    @(negedge clk);
    i_Rst_n = 1'b1;
    @(negedge clk);

    // Latency of a single addi.
    drive(tab[0], 1'b1);
    cycle();
    i_Valid = 1'b0;
    #1 chk("lat_cycle1_valid", {63'd0, o_Valid}, 64'd0);
    cycle();
    #1 chk("lat_cycle2_valid", {63'd0, o_Valid}, 64'd1);
    cycle();
    drain();

    // Whole table back-to-back at full throughput.
    for (int k = 0; k < 16; k++) begin
      drive(tab[k], 1'b1);
      #1 chk("full_rate_ready", {63'd0, o_Ready}, 64'd1);
      cycle();
    end
    drain();

    // Backpressure: two words held, third waits; addresses reloaded to 0.
    i_Ready = 1'b0; i_AddrLoad = 1'b1; i_AddrLoadValue = 32'd0;
    drive(tab[1], 1'b1);
    #1 chk("bp_ready_a", {63'd0, o_Ready}, 64'd1);
    cycle();
    i_AddrLoad = 1'b0;
    drive(tab[2], 1'b1);
    #1 chk("bp_ready_b", {63'd0, o_Ready}, 64'd1);
    cycle();
    drive(tab[3], 1'b1);
    #1 chk("bp_ready_c", {63'd0, o_Ready}, 64'd0);
    cycle();
    cycle();
    #1 chk("bp_still_blocked", {63'd0, o_Ready}, 64'd0);
    cycle();
    i_Ready = 1'b1;
    #1 chk("bp_released_ready", {63'd0, o_Ready}, 64'd1);
    cycle();
    drain();

    // Address load with same-cycle accept, load alone, and wrap.
    i_AddrLoad = 1'b1; i_AddrLoadValue = 32'h103;
    drive(tab[4], 1'b1);
    cycle();
    i_AddrLoad = 1'b0;
    drive(tab[5], 1'b1);
    cycle();
    i_Valid = 1'b0; i_AddrLoad = 1'b1; i_AddrLoadValue = 32'h22;
    cycle();
    i_AddrLoad = 1'b0;
    drive(tab[11], 1'b1);
    cycle();
    i_AddrLoad = 1'b1; i_AddrLoadValue = 32'hFFFFFFFE;
    drive(tab[8], 1'b1);
    cycle();
    i_AddrLoad = 1'b0;
    drive(tab[9], 1'b1);
    cycle();
    drain();

    // Flush with two words held; the errored request in the flush cycle is dropped.
    i_Ready = 1'b0;
    drive(tab[0], 1'b1);
    cycle();
    drive(tab[1], 1'b1);
    cycle();
    i_Flush = 1'b1;
    drive(tab[6], 1'b1);
    cycle();
    i_Flush = 1'b0; i_Valid = 1'b0;
    #1 chk("flush_valid", {63'd0, o_Valid}, 64'd0);
    cycle();
    i_Ready = 1'b1;
    drive(tab[3], 1'b1);
    cycle();
    drain();

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      drive(tab[(k % 2 == 0) ? 7 : 13], 1'b1);
      cycle();
    end
    drain();
    chk("errcount_saturated", {56'd0, o_ErrCount}, 64'hFF);

    // Asynchronous reset with words in flight.
    i_Ready = 1'b0;
    drive(tab[2], 1'b1);
    cycle();
    drive(tab[3], 1'b1);
    cycle();
    i_Valid = 1'b0;
    #2 i_Rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'd0, o_Valid}, 64'd0);
    chk("arst_errcount", {56'd0, o_ErrCount}, 64'd0);
    chk("arst_addr", {32'd0, o_Addr}, 64'd0);
    q.delete(); exp_addr = 0; exp_ec = 0; hold_v = 1'b0;
    @(negedge clk);
    i_Rst_n = 1'b1; i_Ready = 1'b1;
    drive(tab[6], 1'b1);
    cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
